execute_stage: RTL and testbench
================================

# execute_stage

Execute slice of the 16-bit five-stage pipeline. It contains the Decode/Execute pipeline register, the operand-forwarding muxes, the 16-bit ALU and the Execute/Memory pipeline register. It takes the decoded control word, register operands and register indices from Decode, and presents ALU result, store operands and control to the Memory stage. Hazard and forwarding decisions are made outside; this block only applies them.

## Interface
Parameters: none (widths fixed: data 16, register index 4, aluOp 4).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- nop_mux_output_in  in  16  control word from Decode (all-zero = bubble)
- srcA_in, srcB_in  in  16 each  register-file read data rd1/rd2
- rs1_decode, rs2_decode, rd_decode  in  4 each  source/destination indices
- select_forward_mux_A, select_forward_mux_B  in  2 each  forwarding selects
- writeback_data  in  16  value being written back (forward source 01)
- wre_execute, write_memory_enable_execute  out  1 each  registered control in EX
- select_writeback_data_mux_execute  out  2  registered writeback select
- aluOp_execute  out  4  registered ALU opcode
- srcA_execute, srcB_execute  out  16 each  registered operands (pre-forwarding)
- rs1_execute, rs2_execute, rd_execute  out  4 each  registered indices (to hazard/forward units)
- alu_result_execute  out  16  combinational ALU result
- wre_memory, write_memory_enable_memory  out  1 each
- select_writeback_data_mux_memory  out  2
- alu_result_memory, srcA_memory, srcB_memory  out  16 each
- rd_memory  out  4

## Operation
- Control word fields: [15] wre, [14] write_memory_enable, [13:12] select_writeback_data_mux, [11:8] aluOp, [7:0] reserved (ignored).
- Forward mux (A and B identical): 00 → srcX_execute, 01 → writeback_data, 10 → alu_result_memory, 11 → srcX_execute.
- ALU on forwarded operands A, B; result truncated to 16 bits: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SLL A by B[3:0], 6 SRL, 7 SRA, 8 SLT signed (1/0), 9 SLTU, A MUL low 16 bits, B pass A, C pass B, D NOT A, E/F → 0.
- Overflow/carry are discarded; no flag outputs.
- EX/MEM captures wre, write_memory_enable, writeback select, rd, alu_result_execute and the forwarded operands A→srcA_memory (memory address), B→srcB_memory (store data).
- A zero control word propagates as a bubble: no register write, no memory write, aluOp ADD.

## Timing
- Reset low: every registered output is 0 immediately, independent of clk. alu_result_execute is then ALU(ADD, forwarded operands), equal to 0 when selects are 00.
- First rising edge with reset high loads live data.
- ID/EX and EX/MEM update every rising edge. There is no enable or stall; stalls are injected upstream as zero control words.
- Latency: Decode inputs appear at *_execute one edge later. The corresponding *_memory values appear one further edge later (2 cycles total).
- ALU and forward muxes are purely combinational within the EX cycle. A forward select change affects alu_result_execute in the same cycle.
- Reset asserted mid-stream: all in-flight instructions in both registers are discarded.

## Configuration
- EXECUTE_STAGE_FORWARDING_EN defined: forward muxes active as specified.
- EXECUTE_STAGE_FORWARDING_EN undefined: ALU A = srcA_execute and B = srcB_execute. Select inputs and writeback_data are ignored. srcA_memory/srcB_memory take the unforwarded operands.

## Structure
- Package execute_stage_pkg: aluop enum (4-bit), forward-select enum (2-bit), control-word bit-position constants, data width constant 16.
- Sub-module execute_alu: combinational (aluOp, A, B) → result. Registers and muxes stay in execute_stage.

## Test plan
- Reset: drive all inputs nonzero, reset=0 between edges → all registered outputs 0 at once. Release → first edge loads.
- ADD path: control 16'h8000 | aluOp 0, srcA=0x0005, srcB=0x0003, rd=4 → alu_result_execute=0x0008 after edge 1. alu_result_memory=0x0008, rd_memory=4, wre_memory=1 after edge 2.
- Opcode sweep: A=0x8001, B=0x0004 → SUB 0x7FFD, SLL 0x0010, SRL 0x0800, SRA 0xF800, SLT 1, SLTU 0, MUL 0x0004, op F 0.
- Forwarding: srcA_execute=1, writeback_data=0x1234, alu_result_memory=0xBEEF. Select A 01 → A=0x1234; 10 → A=0xBEEF; 11 → A=1. With the macro undefined, A=1 in all cases.
- Store: control with write_memory_enable=1, wre=0; srcA=0x0010, srcB=0x00AA → after 2 edges write_memory_enable_memory=1, srcA_memory=0x0010, srcB_memory=0x00AA.
- Bubble: control 0 between two live ops → the bubble cycle shows wre_memory=0 and write_memory_enable_memory=0, neighbouring results intact.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the execute slice: ALU opcodes, forward selects,
// control-word field positions and the datapath width.
package execute_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;

    localparam int unsigned CW_WRE    = 15;
    localparam int unsigned CW_WME    = 14;
    localparam int unsigned CW_WB_HI  = 13;
    localparam int unsigned CW_WB_LO  = 12;
    localparam int unsigned CW_OP_HI  = 11;
    localparam int unsigned CW_OP_LO  = 8;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_SLL    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_SLT    = 4'h8,
        ALU_SLTU   = 4'h9,
        ALU_MUL    = 4'hA,
        ALU_PASSA  = 4'hB,
        ALU_PASSB  = 4'hC,
        ALU_NOTA   = 4'hD,
        ALU_RSVD_E = 4'hE,
        ALU_RSVD_F = 4'hF
    } aluop_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational 16-bit ALU; results are truncated to the datapath width, no flags.
module execute_alu
    import execute_stage_pkg::*;
(
    input  logic [REG_W-1:0]  alu_op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    logic [3:0] shamt;
    assign shamt = b_i[3:0];

    always_comb begin
        result_o = '0;
        case (aluop_e'(alu_op_i))
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SLL:   result_o = a_i << shamt;
            ALU_SRL:   result_o = a_i >> shamt;
            ALU_SRA:   result_o = $signed(a_i) >>> shamt;
            ALU_SLT:   result_o = {15'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  result_o = {15'b0, a_i < b_i};
            ALU_MUL:   result_o = a_i * b_i;
            ALU_PASSA: result_o = a_i;
            ALU_PASSB: result_o = b_i;
            ALU_NOTA:  result_o = ~a_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute slice: ID/EX register, operand forwarding, ALU and EX/MEM register.
// Forwarding muxes are built only when EXECUTE_STAGE_FORWARDING_EN is defined.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] nop_mux_output_in,
    input  logic [DATA_W-1:0] srcA_in,
    input  logic [DATA_W-1:0] srcB_in,
    input  logic [REG_W-1:0]  rs1_decode,
    input  logic [REG_W-1:0]  rs2_decode,
    input  logic [REG_W-1:0]  rd_decode,
    input  logic [1:0]        select_forward_mux_A,
    input  logic [1:0]        select_forward_mux_B,
    input  logic [DATA_W-1:0] writeback_data,
    output logic              wre_execute,
    output logic              write_memory_enable_execute,
    output logic [1:0]        select_writeback_data_mux_execute,
    output logic [REG_W-1:0]  aluOp_execute,
    output logic [DATA_W-1:0] srcA_execute,
    output logic [DATA_W-1:0] srcB_execute,
    output logic [REG_W-1:0]  rs1_execute,
    output logic [REG_W-1:0]  rs2_execute,
    output logic [REG_W-1:0]  rd_execute,
    output logic [DATA_W-1:0] alu_result_execute,
    output logic              wre_memory,
    output logic              write_memory_enable_memory,
    output logic [1:0]        select_writeback_data_mux_memory,
    output logic [DATA_W-1:0] alu_result_memory,
    output logic [DATA_W-1:0] srcA_memory,
    output logic [DATA_W-1:0] srcB_memory,
    output logic [REG_W-1:0]  rd_memory
);

    logic              wre_ex_q, wme_ex_q;
    logic [1:0]        wb_ex_q;
    logic [REG_W-1:0]  op_ex_q, rs1_ex_q, rs2_ex_q, rd_ex_q;
    logic [DATA_W-1:0] a_ex_q, b_ex_q;

    logic              wre_mem_q, wme_mem_q;
    logic [1:0]        wb_mem_q;
    logic [REG_W-1:0]  rd_mem_q;
    logic [DATA_W-1:0] res_mem_q, a_mem_q, b_mem_q;

    logic [DATA_W-1:0] op_a, op_b, alu_res;

    logic unused_cw_reserved;
    assign unused_cw_reserved = ^nop_mux_output_in[CW_OP_LO-1:0];

`ifdef EXECUTE_STAGE_FORWARDING_EN
    always_comb begin
        op_a = a_ex_q;
        op_b = b_ex_q;
        case (fwd_sel_e'(select_forward_mux_A))
            FWD_WB:  op_a = writeback_data;
            FWD_MEM: op_a = res_mem_q;
            default: op_a = a_ex_q;
        endcase
        case (fwd_sel_e'(select_forward_mux_B))
            FWD_WB:  op_b = writeback_data;
            FWD_MEM: op_b = res_mem_q;
            default: op_b = b_ex_q;
        endcase
    end
`else
    assign op_a = a_ex_q;
    assign op_b = b_ex_q;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{select_forward_mux_A, select_forward_mux_B, writeback_data};
`endif

    execute_alu u_alu (
        .alu_op_i (op_ex_q),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wre_ex_q <= 1'b0;
            wme_ex_q <= 1'b0;
            wb_ex_q  <= '0;
            op_ex_q  <= '0;
            a_ex_q   <= '0;
            b_ex_q   <= '0;
            rs1_ex_q <= '0;
            rs2_ex_q <= '0;
            rd_ex_q  <= '0;
        end else begin
            wre_ex_q <= nop_mux_output_in[CW_WRE];
            wme_ex_q <= nop_mux_output_in[CW_WME];
            wb_ex_q  <= nop_mux_output_in[CW_WB_HI:CW_WB_LO];
            op_ex_q  <= nop_mux_output_in[CW_OP_HI:CW_OP_LO];
            a_ex_q   <= srcA_in;
            b_ex_q   <= srcB_in;
            rs1_ex_q <= rs1_decode;
            rs2_ex_q <= rs2_decode;
            rd_ex_q  <= rd_decode;
        end
    end

    // Memory stage sees the forwarded operands: A is the address, B the store data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wre_mem_q <= 1'b0;
            wme_mem_q <= 1'b0;
            wb_mem_q  <= '0;
            rd_mem_q  <= '0;
            res_mem_q <= '0;
            a_mem_q   <= '0;
            b_mem_q   <= '0;
        end else begin
            wre_mem_q <= wre_ex_q;
            wme_mem_q <= wme_ex_q;
            wb_mem_q  <= wb_ex_q;
            rd_mem_q  <= rd_ex_q;
            res_mem_q <= alu_res;
            a_mem_q   <= op_a;
            b_mem_q   <= op_b;
        end
    end

    assign wre_execute                       = wre_ex_q;
    assign write_memory_enable_execute       = wme_ex_q;
    assign select_writeback_data_mux_execute = wb_ex_q;
    assign aluOp_execute                     = op_ex_q;
    assign srcA_execute                      = a_ex_q;
    assign srcB_execute                      = b_ex_q;
    assign rs1_execute                       = rs1_ex_q;
    assign rs2_execute                       = rs2_ex_q;
    assign rd_execute                        = rd_ex_q;
    assign alu_result_execute                = alu_res;
    assign wre_memory                        = wre_mem_q;
    assign write_memory_enable_memory        = wme_mem_q;
    assign select_writeback_data_mux_memory  = wb_mem_q;
    assign alu_result_memory                 = res_mem_q;
    assign srcA_memory                       = a_mem_q;
    assign srcB_memory                       = b_mem_q;
    assign rd_memory                         = rd_mem_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic
// compared every cycle against a transaction-level pipeline model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] nop_mux_output_in, srcA_in, srcB_in, writeback_data;
    logic [3:0]  rs1_decode, rs2_decode, rd_decode;
    logic [1:0]  select_forward_mux_A, select_forward_mux_B;

    logic        wre_execute, write_memory_enable_execute;
    logic [1:0]  select_writeback_data_mux_execute;
    logic [3:0]  aluOp_execute, rs1_execute, rs2_execute, rd_execute;
    logic [15:0] srcA_execute, srcB_execute, alu_result_execute;
    logic        wre_memory, write_memory_enable_memory;
    logic [1:0]  select_writeback_data_mux_memory;
    logic [15:0] alu_result_memory, srcA_memory, srcB_memory;
    logic [3:0]  rd_memory;

    execute_stage dut (
        .clk                               (clk),
        .reset                             (reset),
        .nop_mux_output_in                 (nop_mux_output_in),
        .srcA_in                           (srcA_in),
        .srcB_in                           (srcB_in),
        .rs1_decode                        (rs1_decode),
        .rs2_decode                        (rs2_decode),
        .rd_decode                         (rd_decode),
        .select_forward_mux_A              (select_forward_mux_A),
        .select_forward_mux_B              (select_forward_mux_B),
        .writeback_data                    (writeback_data),
        .wre_execute                       (wre_execute),
        .write_memory_enable_execute       (write_memory_enable_execute),
        .select_writeback_data_mux_execute (select_writeback_data_mux_execute),
        .aluOp_execute                     (aluOp_execute),
        .srcA_execute                      (srcA_execute),
        .srcB_execute                      (srcB_execute),
        .rs1_execute                       (rs1_execute),
        .rs2_execute                       (rs2_execute),
        .rd_execute                        (rd_execute),
        .alu_result_execute                (alu_result_execute),
        .wre_memory                        (wre_memory),
        .write_memory_enable_memory        (write_memory_enable_memory),
        .select_writeback_data_mux_memory  (select_writeback_data_mux_memory),
        .alu_result_memory                 (alu_result_memory),
        .srcA_memory                       (srcA_memory),
        .srcB_memory                       (srcB_memory),
        .rd_memory                         (rd_memory)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic definitions (shifts as multiply/divide by powers of two).
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint d  = longint'(1) << b[3:0];
        longint q;
        case (op)
            4'h0: q = ua + ub;
            4'h1: q = ua - ub;
            4'h2: q = longint'(a & b);
            4'h3: q = longint'(a | b);
            4'h4: q = longint'(a ^ b);
            4'h5: q = ua * d;
            4'h6: q = ua / d;
            4'h7: q = (sa >= 0) ? sa / d : (sa - (d - 1)) / d;
            4'h8: q = (sa < sb) ? 1 : 0;
            4'h9: q = (ua < ub) ? 1 : 0;
            4'hA: q = ua * ub;
            4'hB: q = ua;
            4'hC: q = ub;
            4'hD: q = 65535 - ua;
            default: q = 0;
        endcase
        return q[15:0];
    endfunction

    function automatic logic [15:0] fwd(input logic [1:0] sel, input logic [15:0] reg_val,
                                        input logic [15:0] wbd, input logic [15:0] memres);
`ifdef EXECUTE_STAGE_FORWARDING_EN
        if (sel == 2'b01) return wbd;
        if (sel == 2'b10) return memres;
`endif
        return reg_val;
    endfunction

    typedef struct packed {
        logic wre; logic wme; logic [1:0] wb; logic [3:0] op;
        logic [15:0] a; logic [15:0] b; logic [3:0] rs1; logic [3:0] rs2; logic [3:0] rd;
    } ex_t;
    typedef struct packed {
        logic wre; logic wme; logic [1:0] wb; logic [3:0] rd;
        logic [15:0] res; logic [15:0] a; logic [15:0] b;
    } mem_t;

    ex_t  m_ex;
    mem_t m_mem;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ex  = '0;
            m_mem = '0;
        end else begin
            logic [15:0] fa, fb;
            fa = fwd(select_forward_mux_A, m_ex.a, writeback_data, m_mem.res);
            fb = fwd(select_forward_mux_B, m_ex.b, writeback_data, m_mem.res);
            m_mem = '{wre: m_ex.wre, wme: m_ex.wme, wb: m_ex.wb, rd: m_ex.rd,
                      res: alu_ref(m_ex.op, fa, fb), a: fa, b: fb};
            m_ex = '{wre: nop_mux_output_in[15], wme: nop_mux_output_in[14],
                     wb: nop_mux_output_in[13:12], op: nop_mux_output_in[11:8],
                     a: srcA_in, b: srcB_in, rs1: rs1_decode, rs2: rs2_decode, rd: rd_decode};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [15:0] fa, fb;
            fa = fwd(select_forward_mux_A, m_ex.a, writeback_data, m_mem.res);
            fb = fwd(select_forward_mux_B, m_ex.b, writeback_data, m_mem.res);
            chk("ex_ctrl", {wre_execute, write_memory_enable_execute,
                            select_writeback_data_mux_execute, aluOp_execute},
                           {m_ex.wre, m_ex.wme, m_ex.wb, m_ex.op});
            chk("ex_ops", {srcA_execute, srcB_execute}, {m_ex.a, m_ex.b});
            chk("ex_idx", {rs1_execute, rs2_execute, rd_execute}, {m_ex.rs1, m_ex.rs2, m_ex.rd});
            chk("alu_ex", alu_result_execute, alu_ref(m_ex.op, fa, fb));
            chk("mem_ctrl", {wre_memory, write_memory_enable_memory,
                             select_writeback_data_mux_memory, rd_memory},
                            {m_mem.wre, m_mem.wme, m_mem.wb, m_mem.rd});
            chk("mem_res", alu_result_memory, m_mem.res);
            chk("mem_ops", {srcA_memory, srcB_memory}, {m_mem.a, m_mem.b});
        end
    end

    task automatic drv(input logic [15:0] cw, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] r1, input logic [3:0] r2, input logic [3:0] rd,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [15:0] wbd);
        nop_mux_output_in    = cw;
        srcA_in              = a;
        srcB_in              = b;
        rs1_decode           = r1;
        rs2_decode           = r2;
        rd_decode            = rd;
        select_forward_mux_A = sa;
        select_forward_mux_B = sb;
        writeback_data       = wbd;
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_regs_zero(input string name);
        chk({name, "_ex"}, {wre_execute, write_memory_enable_execute, select_writeback_data_mux_execute,
                            aluOp_execute, srcA_execute, srcB_execute, rs1_execute, rs2_execute,
                            rd_execute}, 64'h0);
        chk({name, "_mem"}, {wre_memory, write_memory_enable_memory, select_writeback_data_mux_memory,
                             alu_result_memory, srcA_memory, srcB_memory, rd_memory}, 64'h0);
    endtask

    initial begin
        logic [3:0]  op_tab  [8];
        logic [15:0] exp_tab [8];
        logic [15:0] fwd_exp [4];

        reset = 1'b1;
        drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        #1 reset = 1'b0;
        #2 cmp_en = 1'b1;

        // Reset held with live-looking inputs: nothing loads.
        drv(16'hF3A5, 16'h1111, 16'h2222, 4'h1, 4'h2, 4'h3, 2'b00, 2'b00, 16'h5555);
        nxt();
        nxt();
        chk_regs_zero("reset_hold");
        chk("reset_alu", alu_result_execute, 16'h0);
        reset = 1'b1;
        nxt();
        chk("first_load", {srcA_execute, rd_execute, aluOp_execute}, {16'h1111, 4'h3, 4'h3});
        nxt();
        reset = 1'b0;
        #1 chk_regs_zero("async_reset");
        nxt();
        reset = 1'b1;

        // ADD path
        drv(16'h8000, 16'h0005, 16'h0003, 4'h1, 4'h2, 4'h4, 2'b00, 2'b00, 16'h0);
        nxt();
        drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        #1 chk("add_ex", {alu_result_execute, rd_execute}, {16'h0008, 4'h4});
        nxt();
        #1 chk("add_mem", {alu_result_memory, rd_memory, wre_memory}, {16'h0008, 4'h4, 1'b1});

        // Opcode sweep with A=0x8001, B=0x0004
        op_tab[0] = 4'h1; exp_tab[0] = 16'h7FFD;
        op_tab[1] = 4'h5; exp_tab[1] = 16'h0010;
        op_tab[2] = 4'h6; exp_tab[2] = 16'h0800;
        op_tab[3] = 4'h7; exp_tab[3] = 16'hF800;
        op_tab[4] = 4'h8; exp_tab[4] = 16'h0001;
        op_tab[5] = 4'h9; exp_tab[5] = 16'h0000;
        op_tab[6] = 4'hA; exp_tab[6] = 16'h0004;
        op_tab[7] = 4'hF; exp_tab[7] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            chk("model_pin", alu_ref(op_tab[i], 16'h8001, 16'h0004), exp_tab[i]);
            nxt();
            drv({4'h8, op_tab[i], 8'h00}, 16'h8001, 16'h0004, 4'h0, 4'h0, 4'h1, 2'b00, 2'b00, 16'h0);
            nxt();
            drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
            #1 chk("op_sweep", {aluOp_execute, alu_result_execute}, {op_tab[i], exp_tab[i]});
        end

        // Forwarding: MEM holds 0xBEEF, EX holds srcA=1 with PASS A
`ifdef EXECUTE_STAGE_FORWARDING_EN
        fwd_exp[0] = 16'h0001; fwd_exp[1] = 16'h1234; fwd_exp[2] = 16'hBEEF; fwd_exp[3] = 16'h0001;
`else
        fwd_exp[0] = 16'h0001; fwd_exp[1] = 16'h0001; fwd_exp[2] = 16'h0001; fwd_exp[3] = 16'h0001;
`endif
        nxt();
        drv(16'h0C00, 16'h0000, 16'hBEEF, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h1234);
        nxt();
        drv(16'h0B00, 16'h0001, 16'h0000, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h1234);
        nxt();
        drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h1234);
        #1 chk("fwd_memres", alu_result_memory, 16'hBEEF);
        for (int s = 0; s < 4; s++) begin
            select_forward_mux_A = 2'(s);
            #1 chk("fwd_A", alu_result_execute, fwd_exp[s]);
        end
        select_forward_mux_A = 2'b00;

        // Store
        nxt();
        drv(16'h4000, 16'h0010, 16'h00AA, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        nxt();
        drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        nxt();
        #1 chk("store_mem", {write_memory_enable_memory, wre_memory, srcA_memory, srcB_memory},
                            {1'b1, 1'b0, 16'h0010, 16'h00AA});

        // Bubble between two live ops
        drv(16'h8000, 16'h0001, 16'h0002, 4'h0, 4'h0, 4'h3, 2'b00, 2'b00, 16'h0);
        nxt();
        drv(16'h0000, 16'h0007, 16'h0007, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        nxt();
        drv(16'h8100, 16'h0009, 16'h0004, 4'h0, 4'h0, 4'h5, 2'b00, 2'b00, 16'h0);
        #1 chk("bubble_pre", {alu_result_memory, wre_memory, rd_memory}, {16'h0003, 1'b1, 4'h3});
        nxt();
        drv(16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0, 2'b00, 2'b00, 16'h0);
        #1 chk("bubble_mid", {wre_memory, write_memory_enable_memory}, {1'b0, 1'b0});
        nxt();
        #1 chk("bubble_post", {alu_result_memory, wre_memory, rd_memory}, {16'h0005, 1'b1, 4'h5});

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 3000; i++) begin
            nxt();
            reset = ($urandom_range(63) != 0);
            drv(($urandom_range(7) == 0) ? 16'h0 : 16'($urandom),
                16'($urandom), 16'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom),
                2'($urandom), 2'($urandom), 16'($urandom));
        end
        nxt();
        reset = 1'b1;
        @(negedge clk);
        #1 cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
